// File: rtl/toggle_stream_decoder_pkg.sv
// ---------------------------------------------------------------------------
// toggle_codec_pkg: shared types and default constants for the toggle line codec
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package toggle_codec_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } dec_state_t;

  localparam int         c_DEF_DATA_W   = 8;
  localparam int         c_DEF_SYNC_W   = 8;
  localparam logic [7:0] c_DEF_SYNC     = 8'hA5;
  localparam int         c_DEF_IDLE_LEN = 12;

endpackage

`default_nettype wire

// File: rtl/toggle_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// toggle_stream_decoder_if: line-sample input and word valid/ready output bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface toggle_stream_decoder_if #(
  parameter int DATA_W = 8
);

  logic              bit_en;
  logic              line_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_active;
  logic              overflow;

  modport master (
    input  bit_en,
    input  line_in,
    input  out_ready,
    output out_data,
    output out_valid,
    output frame_active,
    output overflow
  );

  modport slave (
    output bit_en,
    output line_in,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  frame_active,
    input  overflow
  );

endinterface

`default_nettype wire

// File: rtl/toggle_stream_decoder_bitdec.sv
// ---------------------------------------------------------------------------
// toggle_bit_decoder: recovers a bit as the XOR of consecutive line samples
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_bit_decoder (
  input  wire  clk,
  input  wire  rst,
  input  wire  bit_en_i,
  input  wire  line_in_i,
  output logic bit_o,
  output logic bit_valid_o
);

  logic line_prev_q;

  // Reset level matches the encoder's idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_prev_q <= 1'b0;
    end else if (bit_en_i) begin
      line_prev_q <= line_in_i;
    end
  end

  assign bit_o       = line_in_i ^ line_prev_q;
  assign bit_valid_o = bit_en_i;

endmodule

`default_nettype wire

// File: rtl/toggle_stream_decoder.sv
// ---------------------------------------------------------------------------
// toggle_stream_decoder: sync hunt, LSB-first word assembly and valid/ready output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_stream_decoder
  import toggle_codec_pkg::*;
#(
  parameter int                DATA_W   = c_DEF_DATA_W,
  parameter int                SYNC_W   = c_DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC     = c_DEF_SYNC,
  parameter int                IDLE_LEN = c_DEF_IDLE_LEN
) (
  input wire                      clk,
  input wire                      rst,
  toggle_stream_decoder_if.master bus
);

  localparam int BIT_CNT_W  = $clog2(DATA_W + 1);
  localparam int IDLE_CNT_W = $clog2(IDLE_LEN + 1);
  localparam logic [BIT_CNT_W-1:0]  c_BIT_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [IDLE_CNT_W-1:0] c_IDLE_END = IDLE_CNT_W'(IDLE_LEN);

  logic w_bit;
  logic w_bit_valid;

  toggle_bit_decoder u_bitdec (
    .clk        (clk),
    .rst        (rst),
    .bit_en_i   (bus.bit_en),
    .line_in_i  (bus.line_in),
    .bit_o      (w_bit),
    .bit_valid_o(w_bit_valid)
  );

  dec_state_t              state_q;
  logic [SYNC_W-1:0]       sr_q;
  logic [SYNC_W-1:0]       sr_d;
  logic [DATA_W-1:0]       word_q;
  logic [DATA_W-1:0]       word_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [IDLE_CNT_W-1:0]   idle_q;
  logic [IDLE_CNT_W-1:0]   idle_d;
  logic [DATA_W-1:0]       out_data_q;
  logic                    out_valid_q;
  logic                    overflow_q;
  logic                    w_word_done;

  // New bits enter at the MSB so the first-received bit ends up in the LSB.
  always_comb begin
    sr_d        = {sr_q[SYNC_W-2:0], w_bit};
    word_d      = {w_bit, word_q[DATA_W-1:1]};
    idle_d      = idle_q;
    if (w_bit) begin
      idle_d = '0;
    end else if (idle_q != c_IDLE_END) begin
      idle_d = idle_q + 1'b1;
    end
    w_word_done = (bit_cnt_q == c_BIT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (w_bit_valid) begin
        case (state_q)
          HUNT: begin
            sr_q <= sr_d;
            if (sr_d == SYNC) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
              idle_q    <= '0;
            end
          end
          DATA: begin
            word_q <= word_d;
            idle_q <= idle_d;
            if (w_word_done) begin
              bit_cnt_q <= '0;
              if (out_valid_q && !bus.out_ready) begin
                overflow_q <= 1'b1;
              end else begin
                out_data_q  <= word_d;
                out_valid_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            // Word delivery above still happens when the frame ends on the same bit.
            if (idle_d == c_IDLE_END) begin
              state_q   <= HUNT;
              sr_q      <= '0;
              word_q    <= '0;
              bit_cnt_q <= '0;
              idle_q    <= '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.frame_active = (state_q == DATA);
  assign bus.overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_toggle_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_stream_decoder: scoreboard bench for toggle_stream_decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_toggle_stream_decoder;
  import toggle_codec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic line_lvl = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  toggle_stream_decoder_if #(.DATA_W(8)) bus ();

  toggle_stream_decoder #(
    .DATA_W  (8),
    .SYNC_W  (8),
    .SYNC    (8'hA5),
    .IDLE_LEN(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Accepted words are compared against the scoreboard in order.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: got word %h, expected none", bus.out_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.out_data !== mon_exp) begin
          fails++;
          $display("FAIL scoreboard_word: got %h, expected %h", bus.out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic strobe(input logic lvl);
    bus.bit_en  = 1'b1;
    bus.line_in = lvl;
    line_lvl    = lvl;
    @(posedge clk);
    #1;
    bus.bit_en  = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    strobe(line_lvl ^ b);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = c_DEF_SYNC;
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic test_reset();
    #3;
    tests += 4;
    if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h, expected 00", bus.out_data); end
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL reset_frame_active: got %b, expected 0", bus.frame_active); end
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, expected 0", bus.overflow); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_sync_detect();
    logic [7:0] lv;
    lv = 8'b1100_0110;
    for (int i = 7; i >= 0; i--) begin
      strobe(lv[i]);
      if (i == 1) begin
        tests++;
        if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL sync_early: frame_active got %b, expected 0", bus.frame_active); end
      end
    end
    tests += 2;
    if (bus.frame_active !== 1'b1) begin fails++; $display("FAIL sync_detect: frame_active got %b, expected 1", bus.frame_active); end
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL sync_valid: out_valid got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_word_assembly();
    bus.out_ready = 1'b1;
    sb_q.push_back(8'h3C);
    send_word(8'h3C);
    tests += 2;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL word_valid: got %b, expected 1", bus.out_valid); end
    if (bus.out_data !== 8'h3C) begin fails++; $display("FAIL word_data: got %h, expected 3c", bus.out_data); end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL word_clear: out_valid got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    sb_q.push_back(8'h3C);
    send_word(8'h3C);
    tests++;
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_first: overflow got %b, expected 0", bus.overflow); end
    send_word(8'hC3);
    tests += 3;
    if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse: overflow got %b, expected 1", bus.overflow); end
    if (bus.out_data !== 8'h3C) begin fails++; $display("FAIL ovf_data_held: got %h, expected 3c", bus.out_data); end
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid_held: got %b, expected 1", bus.out_valid); end
    @(posedge clk);
    #1;
    tests++;
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle: overflow got %b, expected 0", bus.overflow); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ovf_drain: out_valid got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h5A;
    bus.out_ready = 1'b0;
    sb_q.push_back(8'hC3);
    send_word(8'hC3);
    sb_q.push_back(8'h5A);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    bus.out_ready = 1'b1;
    send_bit(w[7]);
    tests += 3;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b, expected 1", bus.out_valid); end
    if (bus.out_data !== 8'h5A) begin fails++; $display("FAIL b2b_data: got %h, expected 5a", bus.out_data); end
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b, expected 0", bus.overflow); end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_clear: out_valid got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_idle_end();
    bus.out_ready = 1'b1;
    sb_q.push_back(8'hC3);
    send_word(8'hC3);
    sb_q.push_back(8'h00);
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b0);
      if (i == 7) begin
        tests += 2;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL idle_word_valid: got %b, expected 1", bus.out_valid); end
        if (bus.out_data !== 8'h00) begin fails++; $display("FAIL idle_word_data: got %h, expected 00", bus.out_data); end
      end
      if (i == 10) begin
        tests++;
        if (bus.frame_active !== 1'b1) begin fails++; $display("FAIL idle_early_end: frame_active got %b, expected 1", bus.frame_active); end
      end
    end
    tests++;
    if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL idle_end: frame_active got %b, expected 0", bus.frame_active); end
    send_sync();
    tests++;
    if (bus.frame_active !== 1'b1) begin fails++; $display("FAIL idle_resync: frame_active got %b, expected 1", bus.frame_active); end
  endtask

  task automatic test_reset_mid_frame();
    bus.out_ready = 1'b0;
    send_word(8'h3C);
    tests++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pending: out_valid got %b, expected 1", bus.out_valid); end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    tests += 4;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h, expected 00", bus.out_data); end
    if (bus.frame_active !== 1'b0) begin fails++; $display("FAIL rstmid_frame: got %b, expected 0", bus.frame_active); end
    if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rstmid_overflow: got %b, expected 0", bus.overflow); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    line_lvl = 1'b0;
    bus.out_ready = 1'b1;
    send_sync();
    tests++;
    if (bus.frame_active !== 1'b1) begin fails++; $display("FAIL rstmid_resync: frame_active got %b, expected 1", bus.frame_active); end
    sb_q.push_back(8'h3C);
    send_word(8'h3C);
    tests += 2;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_word_valid: got %b, expected 1", bus.out_valid); end
    if (bus.out_data !== 8'h3C) begin fails++; $display("FAIL rstmid_word_data: got %h, expected 3c", bus.out_data); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.bit_en    = 1'b0;
    bus.line_in   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sync_detect();
    test_word_assembly();
    test_overflow();
    test_back_to_back();
    test_idle_end();
    test_reset_mid_frame();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d words outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
